// File: rtl/ship_ctrl_pkg.sv
// Shared types and constants for the player ship controller.
// Move FSM states, per-frame directions and playfield limits.
package ship_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DELAY,
      S_REPEAT
   } move_st_t;

   typedef enum logic [1:0] {
      D_NONE,
      D_UP,
      D_DOWN
   } dir_t;

   localparam int SHIP_H        = 32;
   localparam int FIRE_Y_OFFSET = 16;
   localparam int SCREEN_H      = 480;
   localparam int BOT_MARGIN    = 13;
   localparam int Y_MIN_DEF     = 15;
   localparam int Y_MAX_DEF     = SCREEN_H - SHIP_H - BOT_MARGIN;

   function automatic dir_t dir_of(input logic up, input logic dn);
      dir_t d;
      d = D_NONE;
      unique case (1'b1)
         (up && !dn): d = D_UP;
         (dn && !up): d = D_DOWN;
         default:     d = D_NONE;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer.
// The level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= s2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ship_ctrl.sv
// Per-frame ship motion sequencer and fire request generator.
// Frame tick is derived from a synchronized falling edge of v_sync.
module ship_ctrl
   import ship_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 12,
   parameter int REPEAT_RATE     = 4,
   parameter int FIRE_COOLDOWN   = 15,
   parameter int Y_MIN           = Y_MIN_DEF,
   parameter int Y_MAX           = Y_MAX_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       v_sync,
   input  logic       btn_up_raw,
   input  logic       btn_down_raw,
   input  logic       btn_fire_raw,
   input  logic [9:0] ship_y,
   output logic       move_up,
   output logic       move_down,
   output logic       fire_req,
   output logic [9:0] fire_y,
   input  logic       fire_ack
);

   logic up_db;
   logic dn_db;
   logic fire_db;
   logic fire_db_q;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_up_raw),
      .level (up_db)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_down_raw),
      .level (dn_db)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fire (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_fire_raw),
      .level (fire_db)
   );

   logic vs1;
   logic vs2;
   logic vs3;
   logic tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs1  <= 1'b0;
         vs2  <= 1'b0;
         vs3  <= 1'b0;
         tick <= 1'b0;
      end else begin
         vs1  <= v_sync;
         vs2  <= vs1;
         vs3  <= vs2;
         tick <= vs3 & ~vs2;
      end
   end

   move_st_t   st;
   move_st_t   st_n;
   dir_t       dir_q;
   dir_t       dir_n;
   dir_t       dir_c;
   dir_t       mv;
   logic [7:0] cnt;
   logic [7:0] cnt_n;
   logic       up_n;
   logic       dn_n;
   logic       go;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= S_IDLE;
         dir_q     <= D_NONE;
         cnt       <= '0;
         move_up   <= 1'b0;
         move_down <= 1'b0;
      end else begin
         st        <= st_n;
         dir_q     <= dir_n;
         cnt       <= cnt_n;
         move_up   <= up_n;
         move_down <= dn_n;
      end
   end

   always_comb begin
      dir_c = dir_of(up_db, dn_db);
      st_n  = st;
      dir_n = dir_q;
      cnt_n = cnt;
      up_n  = move_up;
      dn_n  = move_down;
      go    = 1'b0;
      mv    = D_NONE;
      if (!enable) begin
         st_n  = S_IDLE;
         dir_n = D_NONE;
         cnt_n = '0;
         up_n  = 1'b0;
         dn_n  = 1'b0;
      end else if (tick) begin
         unique case (st)
            S_IDLE: go = (dir_c != D_NONE);
            S_DELAY, S_REPEAT: begin
               if (dir_c == D_NONE) begin
                  st_n = S_IDLE;
               end else if (dir_c != dir_q) begin
                  go = 1'b1;
               end else if (cnt == 8'd1) begin
                  mv    = dir_q;
                  cnt_n = 8'(REPEAT_RATE);
                  st_n  = S_REPEAT;
               end else begin
                  cnt_n = cnt - 8'd1;
               end
            end
            default: st_n = S_IDLE;
         endcase
         // A direction change restarts the sequence with an immediate move
         if (go) begin
            mv    = dir_c;
            dir_n = dir_c;
            cnt_n = 8'(REPEAT_DELAY);
            st_n  = S_DELAY;
         end
         up_n = (mv == D_UP) && (ship_y > 10'(Y_MIN));
         dn_n = (mv == D_DOWN) && (ship_y < 10'(Y_MAX));
      end
   end

   logic       fire_rise;
   logic       press;
   logic [7:0] cool;

   assign fire_rise = fire_db & ~fire_db_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fire_db_q <= 1'b0;
         press     <= 1'b0;
         cool      <= '0;
         fire_req  <= 1'b0;
         fire_y    <= '0;
      end else begin
         fire_db_q <= fire_db;
         if (!enable) begin
            press    <= 1'b0;
            cool     <= '0;
            fire_req <= 1'b0;
         end else begin
            press <= fire_rise | (press & ~tick);
            if (fire_req && fire_ack) begin
               fire_req <= 1'b0;
               cool     <= 8'(FIRE_COOLDOWN);
            end else if (tick) begin
               if (press && !fire_req && cool == '0) begin
                  fire_req <= 1'b1;
                  fire_y   <= ship_y + 10'(FIRE_Y_OFFSET);
               end
               if (cool != '0) cool <= cool - 8'd1;
            end
         end
      end
   end

endmodule
